syst_feeder: RTL
================

# syst_feeder

Input-side driver for a systolic MAC row. Accepts one vector of LANES samples per handshake beat and emits it onto LANES node inputs with diagonal skew: lane k is delayed k cycles relative to lane 0. Each sample carries its valid flag and a partial-sum seed with its own valid, so every node in the row sees matched x and psumm qualifiers. A global stall freezes the skew pipeline so the node array and its feeder stay cycle-aligned.

## Interface
- LANES, 4, number of output lanes (≥1)
- X_WIDTH, 16, sample width (signed)
- SI_WIDTH, 32, partial-sum seed width (signed)

- clk  in  1  clock
- arstn  in  1  reset, synchronous, active-low
- enable  in  1  global advance; low = stall everything
- s_data_i  in  LANES*X_WIDTH  sample vector, lane k in bits [k*X_WIDTH +: X_WIDTH]
- s_valid_i  in  1  vector valid
- s_last_i  in  1  marks final vector of a block
- s_ready_o  out  1  vector accepted when s_valid_i & s_ready_o
- bias_i  in  LANES*SI_WIDTH  per-lane seed (used only with SYST_FEEDER_BIAS_EN)
- x_o  out  LANES*X_WIDTH  skewed samples to node x_i
- valid_x_o  out  LANES  per-lane sample valid
- psumm_o  out  LANES*SI_WIDTH  per-lane seed to node psumm_i
- valid_psumm_o  out  LANES  per-lane seed valid, equal to valid_x_o
- busy_o  out  1  block in flight
- done_o  out  1  one-cycle pulse: last vector left lane LANES-1

## Operation
- s_ready_o = enable & (state != DRAIN) combinationally.
- On accept, lane k data enters a k+1-stage register chain; stage 0 of every lane loads the same cycle.
- Invalid cycles (no accept while enable=1) inject bubbles: valid 0, data held (not zeroed).
- last tag travels with lane LANES-1 only.
- psumm_o[k] = seed register; valid_psumm_o[k] = valid_x_o[k].
- States: IDLE -> STREAM on first accept; STREAM -> DRAIN on accept with s_last_i; DRAIN -> IDLE when tagged sample exits lane LANES-1 (done_o pulses that cycle). Accept with s_last_i from IDLE goes straight to DRAIN.
- busy_o = (state != IDLE).
- Drain counter counts enabled cycles in DRAIN, wraps never (max LANES).

## Timing
- Reset: all valids 0, x_o 0, psumm_o 0, busy_o 0, done_o 0, state IDLE; applies mid-operation, discarding in-flight samples with no done_o.
- Latency: lane k output valid k+1 enabled cycles after accept.
- enable=0: every register, counter and state holds; s_ready_o=0; done_o held low.
- DRAIN duration: LANES enabled cycles; new vector accepted the cycle after done_o.
- Back-to-back accepts produce continuous valids on every lane.
- LANES=1: no skew, 1-cycle latency, DRAIN lasts 1 cycle.

## Configuration
- SYST_FEEDER_BIAS_EN defined: seed registers load bias_i while IDLE and enabled; held constant during STREAM/DRAIN.
- Undefined: seed registers absent, psumm_o constant 0, bias_i ignored.

## Structure
- syst_pkg: feeder_state_t enum (IDLE, STREAM, DRAIN), default LANES/X_WIDTH/SI_WIDTH constants.
- Sub-module syst_delay_line: parameterized DEPTH/WIDTH register chain with enable and valid, synchronous active-low reset of valid bits; instantiated once per lane via generate.

## Test plan
- LANES=4, one vector {4,3,2,1} with last -> lane k shows k+1 at cycle k+1; done_o at cycle 4; busy_o 1 for cycles 1-4.
- Three back-to-back vectors, third with last -> valid_x_o continuous per lane for 3 cycles, done_o once, 3 cycles after final accept+1.
- enable low 2 cycles mid-stream -> outputs frozen, s_ready_o 0, all latencies extended by exactly 2.
- arstn low during DRAIN -> next cycle all valids 0, busy_o 0, no done_o.
- Bias build, bias_i={40,30,20,10} loaded in IDLE, changed during STREAM -> psumm_o stays {40,30,20,10}; non-bias build -> psumm_o 0.
- s_valid_i during DRAIN -> not accepted (s_ready_o 0), accepted cycle after done_o.

Source files
------------

// File: rtl/syst_pkg.sv
// syst_pkg: shared types and default sizes for the systolic row feeder.
// Optional build macro used by syst_feeder: SYST_FEEDER_BIAS_EN.
package syst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    localparam int DEF_LANES    = 4;
    localparam int DEF_X_WIDTH  = 16;
    localparam int DEF_SI_WIDTH = 32;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/syst_delay_line.sv
// syst_delay_line: DEPTH-stage register chain carrying a valid flag and data.
// Valid shifts every enabled cycle; a stage's data only loads when the stage
// feeding it holds a valid sample, so bubbles leave the last data in place.
// Valid and data bits clear on synchronous active-low reset.
module syst_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    // Next-state: shift the chain one stage when enabled, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (en_i) begin
            valid_d[0] = valid_i;
            if (valid_i) begin
                data_d[0] = data_i;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    // Chain registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/syst_feeder.sv
// syst_feeder: skews one LANES-wide sample vector per beat onto a systolic
// MAC row; lane k lags lane 0 by k enabled cycles. A block ends with the
// vector tagged s_last_i; done_o pulses when that tag leaves lane LANES-1.
// Handshake: a vector is accepted in any cycle where s_valid_i and s_ready_o
// are both high; s_ready_o depends only on enable and the FSM state, never
// on s_valid_i. enable low freezes every register, the FSM and done_o.
// Build macro SYST_FEEDER_BIAS_EN: when defined, per-lane seed registers
// capture bias_i while IDLE and drive psumm_o; otherwise psumm_o is zero.
module syst_feeder
    import syst_pkg::*;
#(
    parameter int   LANES    = DEF_LANES,
    parameter int   X_WIDTH  = DEF_X_WIDTH,
    parameter int   SI_WIDTH = DEF_SI_WIDTH,
    localparam int  CNT_W    = cnt_width(LANES)
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      enable,
    input  logic [LANES*X_WIDTH-1:0]  s_data_i,
    input  logic                      s_valid_i,
    input  logic                      s_last_i,
    output logic                      s_ready_o,
    input  logic [LANES*SI_WIDTH-1:0] bias_i,
    output logic [LANES*X_WIDTH-1:0]  x_o,
    output logic [LANES-1:0]          valid_x_o,
    output logic [LANES*SI_WIDTH-1:0] psumm_o,
    output logic [LANES-1:0]          valid_psumm_o,
    output logic                      busy_o,
    output logic                      done_o,
    output feeder_state_t             dbg_state_o,
    output logic [CNT_W-1:0]          dbg_drain_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LANES);

    feeder_state_t    state_q;
    feeder_state_t    state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [CNT_W-1:0] drain_cnt_d;
    logic             accept;
    logic [LANES-1:0] lane_valid;
    logic             last_out;
    logic             done;

    assign s_ready_o = enable & (state_q != DRAIN);
    assign accept    = s_valid_i & s_ready_o;

    // One delay line per lane; only the last lane carries the block-end tag.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == LANES - 1) begin : g_tagged
            logic [X_WIDTH:0] out_w;
            syst_delay_line #(
                .DEPTH (k + 1),
                .WIDTH (X_WIDTH + 1)
            ) u_dl (
                .clk     (clk),
                .arstn   (arstn),
                .en_i    (enable),
                .valid_i (accept),
                .data_i  ({s_last_i, s_data_i[k*X_WIDTH +: X_WIDTH]}),
                .valid_o (lane_valid[k]),
                .data_o  (out_w)
            );
            assign x_o[k*X_WIDTH +: X_WIDTH] = out_w[X_WIDTH-1:0];
            assign last_out                  = out_w[X_WIDTH];
        end else begin : g_plain
            syst_delay_line #(
                .DEPTH (k + 1),
                .WIDTH (X_WIDTH)
            ) u_dl (
                .clk     (clk),
                .arstn   (arstn),
                .en_i    (enable),
                .valid_i (accept),
                .data_i  (s_data_i[k*X_WIDTH +: X_WIDTH]),
                .valid_o (lane_valid[k]),
                .data_o  (x_o[k*X_WIDTH +: X_WIDTH])
            );
        end
    end

    assign valid_x_o     = lane_valid;
    assign valid_psumm_o = lane_valid;

    // The tagged sample reaches lane LANES-1 exactly while draining.
    assign done   = enable & (state_q == DRAIN) & lane_valid[LANES-1] & last_out;
    assign done_o = done;
    assign busy_o = (state_q != IDLE);

    // Next-state and drain counter; nothing moves while enable is low.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = s_last_i ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (accept && s_last_i) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (state_q == DRAIN) begin
                if (drain_cnt_q < CNT_MAX) begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end else begin
                drain_cnt_d = '0;
            end
        end
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign dbg_state_o     = state_q;
    assign dbg_drain_cnt_o = drain_cnt_q;

`ifdef SYST_FEEDER_BIAS_EN
    logic [LANES*SI_WIDTH-1:0] seed_q;
    logic [LANES*SI_WIDTH-1:0] seed_d;

    // Seeds follow bias_i only while idle, then stay fixed for the block.
    always_comb begin
        seed_d = seed_q;
        if (enable && (state_q == IDLE)) begin
            seed_d = bias_i;
        end
    end

    // Seed registers.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            seed_q <= '0;
        end else begin
            seed_q <= seed_d;
        end
    end

    assign psumm_o = seed_q;
`else
    logic unused_bias;
    assign unused_bias = ^bias_i;
    assign psumm_o     = '0;
`endif

endmodule
